// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file write-back arbiter slice:
//   default sizes of the register file and the identifiers of the two
//   write-back requesters.
//   Ports: none (package).
package regfile_wb_arbiter_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int AMOUNT_DEF     = 16;
  localparam int ADDRESSLEN_DEF = 4;

  // Requester identifiers; the value doubles as the bit index in req/grant.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the ALU and LSU write-back handshakes, the issue-side scoreboard
//   update, the scoreboard itself and the register-file write port.
//   Modports:
//     master - requesters/issue logic side (drives valid/rd/data/issue)
//     slave  - arbiter side (drives ready, busy, wEn/rd/data)
//   Optional macro WB_FORWARD_EN adds fwd_valid/fwd_rd/fwd_data to the slave.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int AMOUNT     = AMOUNT_DEF,
  parameter int ADDRESSLEN = ADDRESSLEN_DEF
);

  logic                  alu_valid;
  logic [ADDRESSLEN-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [ADDRESSLEN-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  lsu_ready;

  logic                  issue_en;
  logic [ADDRESSLEN-1:0] issue_rd;
  logic [AMOUNT-1:0]     busy;

  logic                  wEn;
  logic [ADDRESSLEN-1:0] rd;
  logic [XLEN-1:0]       data;

`ifdef WB_FORWARD_EN
  logic                  fwd_valid;
  logic [ADDRESSLEN-1:0] fwd_rd;
  logic [XLEN-1:0]       fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_en, issue_rd,
    input  alu_ready, lsu_ready, busy, wEn, rd, data,
           fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_en, issue_rd,
    output alu_ready, lsu_ready, busy, wEn, rd, data,
           fwd_valid, fwd_rd, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_en, issue_rd,
    input  alu_ready, lsu_ready, busy, wEn, rd, data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_en, issue_rd,
    output alu_ready, lsu_ready, busy, wEn, rd, data
  );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter with a registered last-grant pointer.
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     req[1:0]    - request vector (bit 0 = ALU, bit 1 = LSU)
//     update      - move the pointer to the current winner this cycle
//     grant[1:0]  - one-hot (or zero) grant, combinational from req
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  req_id_e last_q, last_d;

  // Only a contended cycle consults the pointer; the side that won most
  // recently yields.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update && (grant != 2'b00)) begin
      last_d = grant[1] ? REQ_LSU : REQ_ALU;
    end
  end

  // Resetting to "LSU won last" makes the ALU win the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates ALU and LSU write-back requests onto the single register-file
//   write port (one grant per cycle, round-robin on contention, latency 1)
//   and maintains the busy scoreboard of registers with pending writes.
//   Ports:
//     clk, reset - clock, asynchronous active-high reset
//     bus        - regfile_wb_arbiter_if.slave: ALU/LSU valid/ready
//                  requests, issue_en/issue_rd, busy, wEn/rd/data
//   Optional macro WB_FORWARD_EN: drives bus.fwd_valid/fwd_rd/fwd_data with
//   the winning request combinationally in its acceptance cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int AMOUNT     = AMOUNT_DEF,
  parameter int ADDRESSLEN = ADDRESSLEN_DEF
)(
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  logic [1:0]            req;
  logic [1:0]            grant;
  logic [1:0]            accept;
  logic [ADDRESSLEN-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  wen_d, wen_q;
  logic [ADDRESSLEN-1:0] rd_d, rd_q;
  logic [XLEN-1:0]       data_d, data_q;
  logic [AMOUNT-1:0]     busy_d, busy_q;

  assign req = {bus.lsu_valid, bus.alu_valid};

  // Writes to register 0 are accepted but must not move the pointer, so the
  // pointer update is tied to an actual register-file write.
  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (wen_d),
    .grant  (grant)
  );

  // Reset masks acceptance so nothing in flight is taken while it is high.
  assign accept        = grant & {2{~reset}};
  assign bus.alu_ready = accept[REQ_ALU];
  assign bus.lsu_ready = accept[REQ_LSU];

  always_comb begin
    sel_rd   = bus.alu_rd;
    sel_data = bus.alu_data;
    if (accept[REQ_LSU]) begin
      sel_rd   = bus.lsu_rd;
      sel_data = bus.lsu_data;
    end
    wen_d  = (accept != 2'b00) && (sel_rd != '0);
    rd_d   = wen_d ? sel_rd : rd_q;
    data_d = wen_d ? sel_data : data_q;
  end

  // Clear first, then set, so a same-cycle issue to the register being
  // written leaves it busy for the newer instruction.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < AMOUNT; i++) begin
      if (wen_d && (sel_rd == ADDRESSLEN'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (bus.issue_en && (bus.issue_rd == ADDRESSLEN'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign bus.wEn  = wen_q;
  assign bus.rd   = rd_q;
  assign bus.data = data_q;
  assign bus.busy = busy_q;

`ifdef WB_FORWARD_EN
  assign bus.fwd_valid = wen_d;
  assign bus.fwd_rd    = sel_rd;
  assign bus.fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. Expected write-port transfers are
//   queued when a request is accepted; a monitor compares them against the
//   write port one edge later. Handshake and scoreboard values are compared
//   directly against hand-computed constants.
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];

  regfile_wb_arbiter_if #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4)) bus ();

  regfile_wb_arbiter #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let them settle.
  task automatic applyStimulus(input logic av, input logic [3:0] ard,
                               input logic [31:0] adat, input logic lv,
                               input logic [3:0] lrd, input logic [31:0] ldat,
                               input logic ie, input logic [3:0] ird);
    @(negedge clk);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ldat;
    bus.issue_en  = ie;
    bus.issue_rd  = ird;
    #1;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expectWrite(input logic [3:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Write-port monitor: every wEn pulse must match the oldest queued
  // transfer, and a queued transfer must appear on the very next edge.
  always @(posedge clk) begin
    wb_t e;
    #1;
    if (bus.wEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual rd=%0h data=%0h required none",
                 bus.rd, bus.data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wb_rd", 32'(bus.rd), 32'(e.rd));
        checkOutput("wb_data", bus.data, e.data);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_write actual wEn=%b required rd=%0h data=%0h",
               bus.wEn, e.rd, e.data);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 4'd5;
    bus.alu_data  = 32'h5555;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = 4'd0;
    bus.lsu_data  = 32'h0;
    bus.issue_en  = 1'b0;
    bus.issue_rd  = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    $display("[TB] reset state");
    checkOutput("reset_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("reset_wEn", 32'(bus.wEn), 32'd0);
    checkOutput("reset_rd", 32'(bus.rd), 32'd0);
    checkOutput("reset_data", bus.data, 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    idle();
    reset = 1'b0;

    $display("[TB] lone ALU write");
    applyStimulus(1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("lone_alu_ready", 32'(bus.alu_ready), 32'd1);
    checkOutput("lone_lsu_ready", 32'(bus.lsu_ready), 32'd0);
`ifdef WB_FORWARD_EN
    checkOutput("lone_fwd_valid", 32'(bus.fwd_valid), 32'd1);
    checkOutput("lone_fwd_rd", 32'(bus.fwd_rd), 32'd5);
    checkOutput("lone_fwd_data", bus.fwd_data, 32'h1234);
`endif
    expectWrite(4'd5, 32'h1234);
    afterEdge();
    idle();
    afterEdge();
    checkOutput("hold_wEn", 32'(bus.wEn), 32'd0);
    checkOutput("hold_rd", 32'(bus.rd), 32'd5);
    checkOutput("hold_data", bus.data, 32'h1234);

    $display("[TB] contention round-robin");
    doReset();
    applyStimulus(1'b1, 4'd3, 32'hA, 1'b1, 4'd7, 32'hB, 1'b0, 4'd0);
    checkOutput("rr1_alu_ready", 32'(bus.alu_ready), 32'd1);
    checkOutput("rr1_lsu_ready", 32'(bus.lsu_ready), 32'd0);
`ifdef WB_FORWARD_EN
    checkOutput("rr1_fwd_rd", 32'(bus.fwd_rd), 32'd3);
`endif
    expectWrite(4'd3, 32'hA);
    afterEdge();
    applyStimulus(1'b1, 4'd3, 32'hA, 1'b1, 4'd7, 32'hB, 1'b0, 4'd0);
    checkOutput("rr2_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("rr2_lsu_ready", 32'(bus.lsu_ready), 32'd1);
`ifdef WB_FORWARD_EN
    checkOutput("rr2_fwd_valid", 32'(bus.fwd_valid), 32'd1);
    checkOutput("rr2_fwd_rd", 32'(bus.fwd_rd), 32'd7);
    checkOutput("rr2_fwd_data", bus.fwd_data, 32'hB);
`endif
    expectWrite(4'd7, 32'hB);
    afterEdge();
    applyStimulus(1'b1, 4'd3, 32'hA, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("rr3_alu_ready", 32'(bus.alu_ready), 32'd1);
    expectWrite(4'd3, 32'hA);
    afterEdge();
    idle();

    $display("[TB] write to register zero");
    doReset();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd1);
    afterEdge();
    checkOutput("issue1_busy", 32'(bus.busy), 32'h0002);
    applyStimulus(1'b1, 4'd0, 32'hDEAD, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("r0_alu_ready", 32'(bus.alu_ready), 32'd1);
`ifdef WB_FORWARD_EN
    checkOutput("r0_fwd_valid", 32'(bus.fwd_valid), 32'd0);
`endif
    afterEdge();
    checkOutput("r0_wEn", 32'(bus.wEn), 32'd0);
    checkOutput("r0_busy", 32'(bus.busy), 32'h0002);
    applyStimulus(1'b1, 4'd2, 32'h22, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
    checkOutput("r0_rr_alu_ready", 32'(bus.alu_ready), 32'd1);
    checkOutput("r0_rr_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    expectWrite(4'd2, 32'h22);
    afterEdge();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
    checkOutput("r0_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    expectWrite(4'd6, 32'h66);
    afterEdge();

    $display("[TB] busy set and clear");
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    afterEdge();
    checkOutput("issue9_busy", 32'(bus.busy), 32'h0202);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0);
    checkOutput("w9_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    checkOutput("w9_busy_before", 32'(bus.busy), 32'h0202);
    expectWrite(4'd9, 32'h99);
    afterEdge();
    checkOutput("w9_busy_after", 32'(bus.busy), 32'h0002);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4);
    afterEdge();
    checkOutput("issue4_busy", 32'(bus.busy), 32'h0012);
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4);
    checkOutput("w4_alu_ready", 32'(bus.alu_ready), 32'd1);
    expectWrite(4'd4, 32'h44);
    afterEdge();
    checkOutput("set_wins_busy", 32'(bus.busy), 32'h0012);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd0);
    afterEdge();
    checkOutput("issue0_busy", 32'(bus.busy), 32'h0012);

    $display("[TB] asynchronous reset mid-cycle");
    doReset();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
    afterEdge();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    afterEdge();
    applyStimulus(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectWrite(4'd3, 32'h33);
    afterEdge();
    checkOutput("pre_reset_wEn", 32'(bus.wEn), 32'd1);
    checkOutput("pre_reset_busy", 32'(bus.busy), 32'h0220);
    bus.alu_rd   = 4'd7;
    bus.alu_data = 32'h77;
    reset = 1'b1;
    #1;
    checkOutput("async_wEn", 32'(bus.wEn), 32'd0);
    checkOutput("async_rd", 32'(bus.rd), 32'd0);
    checkOutput("async_data", bus.data, 32'h0);
    checkOutput("async_busy", 32'(bus.busy), 32'h0);
    checkOutput("async_alu_ready", 32'(bus.alu_ready), 32'd0);
    @(negedge clk);
    bus.alu_valid = 1'b0;
    reset = 1'b0;
    afterEdge();
    checkOutput("dropped_wEn", 32'(bus.wEn), 32'd0);
    idle();
    afterEdge();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
